loop_nest_sequencer: RTL and testbench
======================================

// Module: loop_nest_sequencer
// PURPOSE
//  Sequences the stride memory walker through a nested loop. Holds per-loop iteration limits and walks
//  the nest outermost->innermost. Emits one loop_init/loop_enter/loop_exit/loop_index_valid/loop_ctrl_done
//  event per cycle on the walker's control inputs. Sits between the instruction decoder and the walkers.
// PARAMETERS
//  LOOP_ID_W   5   loop index width; matches the walker's loop_index
//  MAX_LOOPS   8   nest depth supported (<= 1<<LOOP_ID_W)
//  ITER_W      16  iteration-limit width; stored value = iterations-1
// PORTS
//  clk               in   1          clock
//  reset             in   1          asynchronous, active-low reset
//  start             in   1          pulse: run configured nest (ignored while busy)
//  stall             in   1          1 = freeze FSM/counters, all event outputs forced 0
//  cfg_loop_iter_v   in   1          push one loop limit (IDLE only; first push = loop 0 = outermost)
//  cfg_loop_iter     in   ITER_W     iterations-1 for the pushed loop
//  loop_init         out  1          pulse: walker latches base_addr, clears offsets
//  loop_enter        out  1          pulse: entering loop loop_index
//  loop_exit         out  1          pulse: leaving loop loop_index
//  loop_index        out  LOOP_ID_W  loop id qualifying enter/exit/valid
//  loop_index_valid  out  1          pulse: loop loop_index advances one stride
//  loop_ctrl_done    out  1          pulse: nest complete
//  busy              out  1          1 from start accept through DONE cycle
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; level, push pointer N, all counters 0; every output 0.
//  Config: each cfg_loop_iter_v in IDLE writes lim[N], N++; pushes with N==MAX_LOOPS or outside IDLE dropped.
//  FSM: one event per non-stalled cycle; outputs registered (appear the cycle after the state decision).
//   IDLE  : start & N>0 -> INIT; start & N==0 -> DONE.
//   INIT  : loop_init=1; level<=0 -> ENTER.
//   ENTER : loop_enter=1, idx=level; level==N-1 -> ITER, else level++.
//   ITER  : idx=N-1, loop_index_valid=1, cnt[N-1]++; if cnt==lim: cnt<=0 -> EXIT.
//   EXIT  : loop_exit=1, idx=level; level==0 -> DONE, else level-- -> ADV.
//   ADV   : cnt[level]<lim[level]: valid=1, idx=level, cnt++, level++ -> ENTER;
//           else cnt[level]<=0, loop_exit=1 idx=level; level==0 -> DONE, else level-- (stay ADV).
//   DONE  : loop_ctrl_done=1; N<=0 (config consumed) -> IDLE.
//  Pulses: innermost gets lim+1 valid pulses per entry; outer loops get lim valid pulses per entry.
//  Example (N=2, lim={1,2}, start @0): INIT@1, ENTER0@2, ENTER1@3, V1@4-6, EXIT1@7, V0@8, ENTER1@9,
//   V1@10-12, EXIT1@13, EXIT0@14, DONE@15, busy=0 @16.
//  stall=1: state/level/cnt hold, outputs 0. Sequence resumes unchanged on release. start while stalled in IDLE is dropped.
//  Counters: ITER_W-bit compare only, no wrap. lim=0 gives one iteration. lim=all-ones gives 2^ITER_W.
//  Simultaneous start+cfg in IDLE: cfg push applies, start uses the pre-push N.
//  reset mid-run: immediate IDLE, no done pulse, config lost.
// CONFIGURATION
//  LOOP_SEQ_PERF_EN defined: extra output perf_stall_cycles [31:0] counts stall=1 cycles while busy.
//   Cleared on start accept, saturates at all-ones, held after DONE.
//  LOOP_SEQ_PERF_EN undefined: no port, no logic.
// STRUCTURE
//  Shared package loop_seq_pkg: FSM state encoding (IDLE..DONE), LOOP_ID_W/ITER_W defaults,
//   event-type constants shared with walkers.
//  One sub-module: loop_iter_regfile -- MAX_LOOPS x {lim,cnt}.
//   Write port for cfg push; read/inc/clear port at level.
// TESTING
//  1 N=1, lim=3, start -> INIT, ENTER0, 4x valid idx0, EXIT0, done; busy high 8 cycles.
//  2 N=2, lim={1,2} -> exact cycle trace of BEHAVIOUR example, 6 inner valid, 1 outer valid.
//  3 N=0, start -> loop_ctrl_done the cycle after next, no init/enter/exit.
//  4 stall 3 cycles mid-ITER of test 2 -> identical event order, done 3 cycles later, outputs 0 while stalled.
//  5 reset low during ENTER -> all outputs 0 same cycle; restart after fresh config runs cleanly.
//  6 9 pushes with MAX_LOOPS=8 -> 9th dropped; cfg/start during busy ignored.
//    Optional: PERF count equals stalled cycles.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// Shared types for the loop-nest sequencer and the stride walkers: FSM state
// encoding, default widths and the event codes seen on the walker control inputs.
package loop_seq_pkg;

  localparam int unsigned LOOP_ID_W_DEF = 5;
  localparam int unsigned MAX_LOOPS_DEF = 8;
  localparam int unsigned ITER_W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ENTER,
    ST_ITER,
    ST_EXIT,
    ST_ADV,
    ST_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    EVT_NONE,
    EVT_INIT,
    EVT_ENTER,
    EVT_EXIT,
    EVT_VALID,
    EVT_DONE
  } loop_evt_e;

endpackage

// File: rtl/loop_iter_regfile.sv
// Per-loop iteration limits and live counters. One write port for config
// pushes; one read/increment/clear port at the sequencer's current level.
module loop_iter_regfile
  import loop_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = MAX_LOOPS_DEF,
  parameter int unsigned AW     = 3,
  parameter int unsigned ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [ITER_W-1:0] wr_data,
  input  logic [AW-1:0]     idx,
  input  logic              cnt_inc,
  input  logic              cnt_clr,
  output logic [ITER_W-1:0] lim,
  output logic [ITER_W-1:0] cnt
);

  logic [ITER_W-1:0] lim_q [DEPTH];
  logic [ITER_W-1:0] lim_d [DEPTH];
  logic [ITER_W-1:0] cnt_q [DEPTH];
  logic [ITER_W-1:0] cnt_d [DEPTH];

  always_comb begin
    lim_d = lim_q;
    cnt_d = cnt_q;
    if (wr_en) lim_d[wr_idx] = wr_data;
    if (cnt_clr) cnt_d[idx] = '0;
    else if (cnt_inc) cnt_d[idx] = cnt_q[idx] + ITER_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        lim_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      lim_q <= lim_d;
      cnt_q <= cnt_d;
    end
  end

  assign lim = lim_q[idx];
  assign cnt = cnt_q[idx];

endmodule

// File: rtl/loop_nest_sequencer.sv
// Walks a configured loop nest outermost->innermost, emitting one registered
// walker control event per non-stalled cycle. Define LOOP_SEQ_PERF_EN for perf_stall_cycles.
module loop_nest_sequencer
  import loop_seq_pkg::*;
#(
  parameter int unsigned LOOP_ID_W = LOOP_ID_W_DEF,
  parameter int unsigned MAX_LOOPS = MAX_LOOPS_DEF,
  parameter int unsigned ITER_W    = ITER_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 cfg_loop_iter_v,
  input  logic [ITER_W-1:0]    cfg_loop_iter,
  output logic                 loop_init,
  output logic                 loop_enter,
  output logic                 loop_exit,
  output logic [LOOP_ID_W-1:0] loop_index,
  output logic                 loop_index_valid,
  output logic                 loop_ctrl_done,
`ifdef LOOP_SEQ_PERF_EN
  output logic [31:0]          perf_stall_cycles,
`endif
  output logic                 busy
);

  // NW holds 0..MAX_LOOPS; AW addresses 0..MAX_LOOPS-1
  localparam int unsigned NW = $clog2(MAX_LOOPS + 1);
  localparam int unsigned AW = (MAX_LOOPS > 1) ? $clog2(MAX_LOOPS) : 1;

  seq_state_e           state_q, state_d;
  logic [AW-1:0]        level_q, level_d;
  logic [NW-1:0]        num_q, num_d;
  logic [AW-1:0]        last_lvl;
  loop_evt_e            evt_d;
  logic [LOOP_ID_W-1:0] idx_q, idx_d;
  logic                 init_q, enter_q, exit_q, valid_q, done_q, busy_q, busy_d;
  logic                 cfg_push, cnt_inc, cnt_clr;
  logic [ITER_W-1:0]    lim, cnt;

  assign last_lvl = AW'(num_q - NW'(1));

  loop_iter_regfile #(
    .DEPTH  (MAX_LOOPS),
    .AW     (AW),
    .ITER_W (ITER_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (cfg_push),
    .wr_idx  (num_q[AW-1:0]),
    .wr_data (cfg_loop_iter),
    .idx     (level_q),
    .cnt_inc (cnt_inc),
    .cnt_clr (cnt_clr),
    .lim     (lim),
    .cnt     (cnt)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    num_d    = num_q;
    evt_d    = EVT_NONE;
    idx_d    = '0;
    cfg_push = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    if (!stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_loop_iter_v && (num_q < NW'(MAX_LOOPS))) begin
            cfg_push = 1'b1;
            num_d    = num_q + NW'(1);
          end
          // start decides on the pre-push depth
          if (start) state_d = (num_q != '0) ? ST_INIT : ST_DONE;
        end
        ST_INIT: begin
          evt_d   = EVT_INIT;
          level_d = '0;
          state_d = ST_ENTER;
        end
        ST_ENTER: begin
          evt_d = EVT_ENTER;
          idx_d = LOOP_ID_W'(level_q);
          if (level_q == last_lvl) state_d = ST_ITER;
          else level_d = level_q + AW'(1);
        end
        ST_ITER: begin
          evt_d = EVT_VALID;
          idx_d = LOOP_ID_W'(level_q);
          if (cnt == lim) begin
            cnt_clr = 1'b1;
            state_d = ST_EXIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_EXIT: begin
          evt_d = EVT_EXIT;
          idx_d = LOOP_ID_W'(level_q);
          if (level_q == '0) state_d = ST_DONE;
          else begin
            level_d = level_q - AW'(1);
            state_d = ST_ADV;
          end
        end
        ST_ADV: begin
          idx_d = LOOP_ID_W'(level_q);
          if (cnt < lim) begin
            evt_d   = EVT_VALID;
            cnt_inc = 1'b1;
            level_d = level_q + AW'(1);
            state_d = ST_ENTER;
          end else begin
            // exhausted outer loop: exit it and keep unwinding
            evt_d   = EVT_EXIT;
            cnt_clr = 1'b1;
            if (level_q == '0) state_d = ST_DONE;
            else level_d = level_q - AW'(1);
          end
        end
        ST_DONE: begin
          evt_d   = EVT_DONE;
          num_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      init_q  <= 1'b0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      init_q  <= (evt_d == EVT_INIT);
      enter_q <= (evt_d == EVT_ENTER);
      exit_q  <= (evt_d == EVT_EXIT);
      valid_q <= (evt_d == EVT_VALID);
      done_q  <= (evt_d == EVT_DONE);
      busy_q  <= busy_d;
    end
  end

  assign loop_init        = init_q;
  assign loop_enter       = enter_q;
  assign loop_exit        = exit_q;
  assign loop_index       = idx_q;
  assign loop_index_valid = valid_q;
  assign loop_ctrl_done   = done_q;
  assign busy             = busy_q;

`ifdef LOOP_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && start && !stall) perf_d = '0;
    else if (busy_q && stall && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Directed-vector bench for loop_nest_sequencer: per-cycle event traces
// compared against hand-derived expectations.
module tb_loop_nest_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, cfg_v;
  logic [15:0] cfg;
  logic        loop_init, loop_enter, loop_exit, loop_index_valid, loop_ctrl_done, busy;
  logic [4:0]  loop_index;
`ifdef LOOP_SEQ_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  loop_nest_sequencer #(
    .LOOP_ID_W (5),
    .MAX_LOOPS (8),
    .ITER_W    (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stall            (stall),
    .cfg_loop_iter_v  (cfg_v),
    .cfg_loop_iter    (cfg),
    .loop_init        (loop_init),
    .loop_enter       (loop_enter),
    .loop_exit        (loop_exit),
    .loop_index       (loop_index),
    .loop_index_valid (loop_index_valid),
    .loop_ctrl_done   (loop_ctrl_done),
`ifdef LOOP_SEQ_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .busy             (busy)
  );

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_INIT = 5'b10000;
  localparam logic [4:0] K_ENT  = 5'b01000;
  localparam logic [4:0] K_EXT  = 5'b00100;
  localparam logic [4:0] K_VAL  = 5'b00010;
  localparam logic [4:0] K_DONE = 5'b00001;

  logic [10:0] exp_q[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {busy, init, enter, exit, valid, done, index}; index only meaningful with an event
  function automatic logic [10:0] obs_now();
    logic [4:0] k;
    k = {loop_init, loop_enter, loop_exit, loop_index_valid, loop_ctrl_done};
    return {busy, k, (k != 5'd0) ? loop_index : 5'd0};
  endfunction

  task automatic e(input logic b, input logic [4:0] k, input int unsigned i, input int unsigned n);
    for (int unsigned j = 0; j < n; j++) exp_q.push_back({b, k, 5'(i)});
  endtask

  task automatic push(input logic [15:0] v);
    @(posedge clk); #1;
    cfg_v = 1'b1;
    cfg   = v;
    @(posedge clk); #1;
    cfg_v = 1'b0;
  endtask

  // start is raised in cycle 0; exp_q[i] is checked in cycle i+1
  task automatic run(input string tag, input int sf, input int st, input int inj);
    start = 1'b1;
    foreach (exp_q[i]) begin
      @(posedge clk); #1;
      start = (i + 1 == inj);
      cfg_v = (i + 1 == inj);
      cfg   = 16'd5;
      stall = (i + 1 >= sf) && (i + 1 <= st);
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, i + 1), 32'(obs_now()), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nval;
    bit seen;
    reset = 1'b0; start = 1'b0; stall = 1'b0; cfg_v = 1'b0; cfg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 32'(obs_now()), 32'd0);
    reset = 1'b1;

    // 1: single loop, lim=3
    push(16'd3);
    e(1, K_NONE, 0, 1); e(1, K_INIT, 0, 1); e(1, K_ENT, 0, 1); e(1, K_VAL, 0, 4);
    e(1, K_EXT, 0, 1); e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 1);
    run("t1", 0, -1, -1);

    // 2: two loops, lim0=1 lim1=2
    push(16'd1); push(16'd2);
    e(1, K_NONE, 0, 1); e(1, K_INIT, 0, 1); e(1, K_ENT, 0, 1); e(1, K_ENT, 1, 1);
    e(1, K_VAL, 1, 3); e(1, K_EXT, 1, 1); e(1, K_VAL, 0, 1); e(1, K_ENT, 1, 1);
    e(1, K_VAL, 1, 3); e(1, K_EXT, 1, 1); e(1, K_EXT, 0, 1); e(0, K_DONE, 0, 1);
    e(0, K_NONE, 0, 1);
    run("t2", 0, -1, -1);

    // 3: empty nest, with a cfg push coincident with start; then config must be consumed
    cfg_v = 1'b1; cfg = 16'd7;
    e(1, K_NONE, 0, 1); e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 2);
    run("t3a", 0, -1, -1);
    e(1, K_NONE, 0, 1); e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 1);
    run("t3b", 0, -1, -1);

    // 4: test 2 with stall held in cycles 6..8
    push(16'd1); push(16'd2);
    e(1, K_NONE, 0, 1); e(1, K_INIT, 0, 1); e(1, K_ENT, 0, 1); e(1, K_ENT, 1, 1);
    e(1, K_VAL, 1, 2); e(1, K_NONE, 0, 3); e(1, K_VAL, 1, 1); e(1, K_EXT, 1, 1);
    e(1, K_VAL, 0, 1); e(1, K_ENT, 1, 1); e(1, K_VAL, 1, 3); e(1, K_EXT, 1, 1);
    e(1, K_EXT, 0, 1); e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 1);
    run("t4", 6, 8, -1);
`ifdef LOOP_SEQ_PERF_EN
    chk("perf stall count", perf_stall_cycles, 32'd3);
`endif

    // start while stalled in IDLE is dropped
    @(posedge clk); #1;
    stall = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    stall = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle stall start dropped", 32'(busy), 32'd0);
`ifdef LOOP_SEQ_PERF_EN
    chk("perf held idle", perf_stall_cycles, 32'd3);
`endif

    // 5: reset mid-ENTER, then a fresh single-loop run
    push(16'd0); push(16'd0);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5 pre-reset enter0", 32'(obs_now()), 32'({1'b1, K_ENT, 5'd0}));
    reset = 1'b0;
    #1;
    chk("t5 async reset outputs", 32'(obs_now()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    push(16'd0);
    e(1, K_NONE, 0, 1); e(1, K_INIT, 0, 1); e(1, K_ENT, 0, 1); e(1, K_VAL, 0, 1);
    e(1, K_EXT, 0, 1); e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 1);
    run("t5", 0, -1, -1);

    // 6: nine pushes, ninth dropped; cfg+start injected while busy
    for (int k = 0; k < 9; k++) push((k == 8) ? 16'd3 : 16'd0);
    e(1, K_NONE, 0, 1); e(1, K_INIT, 0, 1);
    for (int unsigned l = 0; l < 8; l++) e(1, K_ENT, l, 1);
    e(1, K_VAL, 7, 1);
    for (int l = 7; l >= 0; l--) e(1, K_EXT, l, 1);
    e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 1);
    run("t6", 0, -1, 5);
    e(1, K_NONE, 0, 1); e(0, K_DONE, 0, 1); e(0, K_NONE, 0, 1);
    run("t6 consumed", 0, -1, -1);

    // 7: lim all-ones gives 2^16 innermost pulses
    push(16'hFFFF);
    start = 1'b1;
    nval = 0;
    seen = 1'b0;
    for (int c = 0; c < 70000 && !seen; c++) begin
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      if (loop_index_valid) nval++;
      if (loop_ctrl_done) seen = 1'b1;
    end
    chk("t7 done seen", 32'(seen), 32'd1);
    chk("t7 valid count", 32'(nval), 32'd65536);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
